// File: rtl/ddr_arbit_pkg.sv
// Shared definitions for the four-master DDR read arbiter: FSM encoding,
// master count and default widths.
package ddr_arbit_pkg;

  localparam int NUM_MASTERS        = 4;
  localparam int DEF_DDR_ADDR_WIDTH = 28;
  localparam int DEF_DQ_WIDTH       = 32;
  localparam int DEF_RD_LEN_WIDTH   = 16;
  localparam int DEF_TIMEOUT        = 4096;
  localparam int CMD_LEN_WIDTH      = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/ddr_rd_arbit_rr_pick4.sv
// Combinational round-robin picker: the search begins just after the
// previously granted master and wraps around.
module rr_pick4
  import ddr_arbit_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] last_grant,
  output logic [NUM_MASTERS-1:0] grant
);

  logic [NUM_MASTERS-1:0]   last_eff;
  logic [2*NUM_MASTERS-1:0] req_dbl;
  logic                     seen_last;
  logic                     found;

  // An empty last_grant is treated as "m4 last" so m1 is searched first.
  assign last_eff = (last_grant == '0) ? 4'b1000 : last_grant;
  assign req_dbl  = {req, req};

  always_comb begin
    grant     = '0;
    seen_last = 1'b0;
    found     = 1'b0;
    for (int j = 0; j < 2*NUM_MASTERS; j++) begin
      if (seen_last && !found && req_dbl[j]) begin
        grant[j % NUM_MASTERS] = 1'b1;
        found                  = 1'b1;
      end
      if (last_eff[j % NUM_MASTERS]) seen_last = 1'b1;
    end
  end

endmodule

// File: rtl/ddr_rd_arbit.sv
// Four-master read arbiter in front of a DDR read controller: round-robin
// grant, single outstanding burst, beat routing and sticky error reporting.
module ddr_rd_arbit
  import ddr_arbit_pkg::*;
#(
  parameter int DDR_ADDR_WIDTH = DEF_DDR_ADDR_WIDTH,
  parameter int DQ_WIDTH       = DEF_DQ_WIDTH,
  parameter int RD_LEN_WIDTH   = DEF_RD_LEN_WIDTH,
  parameter int TIMEOUT        = DEF_TIMEOUT
)(
  input  logic                      ddr_clk,
  input  logic                      rst,

  input  logic                      m1_rd_req,
  input  logic [DDR_ADDR_WIDTH-1:0] m1_rd_addr,
  input  logic [RD_LEN_WIDTH-1:0]   m1_rd_len,
  output logic                      m1_rd_rrdy,
  output logic                      m1_rd_rdata_en,
  output logic [8*DQ_WIDTH-1:0]     m1_rd_data,
  output logic                      m1_rd_rdone,

  input  logic                      m2_rd_req,
  input  logic [DDR_ADDR_WIDTH-1:0] m2_rd_addr,
  input  logic [RD_LEN_WIDTH-1:0]   m2_rd_len,
  output logic                      m2_rd_rrdy,
  output logic                      m2_rd_rdata_en,
  output logic [8*DQ_WIDTH-1:0]     m2_rd_data,
  output logic                      m2_rd_rdone,

  input  logic                      m3_rd_req,
  input  logic [DDR_ADDR_WIDTH-1:0] m3_rd_addr,
  input  logic [RD_LEN_WIDTH-1:0]   m3_rd_len,
  output logic                      m3_rd_rrdy,
  output logic                      m3_rd_rdata_en,
  output logic [8*DQ_WIDTH-1:0]     m3_rd_data,
  output logic                      m3_rd_rdone,

  input  logic                      m4_rd_req,
  input  logic [DDR_ADDR_WIDTH-1:0] m4_rd_addr,
  input  logic [RD_LEN_WIDTH-1:0]   m4_rd_len,
  output logic                      m4_rd_rrdy,
  output logic                      m4_rd_rdata_en,
  output logic [8*DQ_WIDTH-1:0]     m4_rd_data,
  output logic                      m4_rd_rdone,

  output logic                      rd_cmd_en,
  output logic [DDR_ADDR_WIDTH-1:0] rd_cmd_addr,
  output logic [CMD_LEN_WIDTH-1:0]  rd_cmd_len,
  input  logic                      rd_cmd_ready,
  input  logic [8*DQ_WIDTH-1:0]     read_data,
  input  logic                      read_data_valid,
  input  logic                      rd_cmd_done,
  output logic                      rd_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  arb_state_t                state;
  logic [NUM_MASTERS-1:0]    req;
  logic [NUM_MASTERS-1:0]    pick;
  logic [NUM_MASTERS-1:0]    grant;
  logic [NUM_MASTERS-1:0]    last_grant;
  logic [DDR_ADDR_WIDTH-1:0] addr_q;
  logic [DDR_ADDR_WIDTH-1:0] pick_addr;
  logic [RD_LEN_WIDTH-1:0]   len_q;
  logic [RD_LEN_WIDTH-1:0]   pick_len;
  logic [RD_LEN_WIDTH-1:0]   beat_cnt;
  logic [TW-1:0]             timer;
  logic                      err_q;
  logic                      live;
  logic                      len_zero;
  logic                      beat_ok;
  logic                      beat_take;
  logic                      deliver;
  logic                      short_done;
  logic                      cmd_ack;
  logic [NUM_MASTERS-1:0]    rrdy_v;
  logic [NUM_MASTERS-1:0]    en_v;
  logic [NUM_MASTERS-1:0]    done_v;

  assign req = {m4_rd_req, m3_rd_req, m2_rd_req, m1_rd_req};

  rr_pick4 u_pick (
    .req        (req),
    .last_grant (last_grant),
    .grant      (pick)
  );

  always_comb begin
    pick_addr = m1_rd_addr;
    pick_len  = m1_rd_len;
    case (pick)
      4'b0010: begin pick_addr = m2_rd_addr; pick_len = m2_rd_len; end
      4'b0100: begin pick_addr = m3_rd_addr; pick_len = m3_rd_len; end
      4'b1000: begin pick_addr = m4_rd_addr; pick_len = m4_rd_len; end
      default: begin pick_addr = m1_rd_addr; pick_len = m1_rd_len; end
    endcase
  end

  assign len_zero  = (len_q == '0);
  assign beat_ok   = (beat_cnt < len_q);
  assign beat_take = (state == ST_DATA) && read_data_valid && beat_ok;
  // A beat arriving alongside rd_cmd_done still counts toward the length.
  assign short_done = beat_take ? ((beat_cnt + RD_LEN_WIDTH'(1)) < len_q) : beat_ok;

  always_ff @(posedge ddr_clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= 4'b1000;
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt   <= '0;
      timer      <= '0;
      err_q      <= 1'b0;
    end else begin
      if (read_data_valid && (state != ST_DATA)) err_q <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            grant  <= pick;
            addr_q <= pick_addr;
            len_q  <= pick_len;
            state  <= ST_CMD;
          end
        end
        ST_CMD: begin
          beat_cnt <= '0;
          timer    <= '0;
          if (len_zero) state <= ST_DONE;
          else if (rd_cmd_ready) state <= ST_DATA;
        end
        ST_DATA: begin
          if (beat_take) beat_cnt <= beat_cnt + RD_LEN_WIDTH'(1);
          if (read_data_valid && !beat_ok) err_q <= 1'b1;
          if (rd_cmd_done) begin
            state <= ST_DONE;
            if (short_done) err_q <= 1'b1;
          end else if (timer == TIMER_LAST) begin
            state <= ST_DONE;
            err_q <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_DONE: begin
          last_grant <= grant;
          grant      <= '0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Every output is masked by reset so nothing leaks while rst is high.
  assign live        = ~rst;
  assign rd_cmd_en   = live && (state == ST_CMD) && !len_zero;
  assign rd_cmd_addr = rd_cmd_en ? addr_q : '0;
  assign rd_cmd_len  = rd_cmd_en ? CMD_LEN_WIDTH'(len_q) : '0;
  assign cmd_ack     = live && (state == ST_CMD) && (len_zero || rd_cmd_ready);
  assign deliver     = live && beat_take;
  assign rrdy_v      = grant & {NUM_MASTERS{cmd_ack}};
  assign en_v        = grant & {NUM_MASTERS{deliver}};
  assign done_v      = grant & {NUM_MASTERS{live && (state == ST_DONE)}};
  assign rd_err      = err_q & live;

  assign m1_rd_rrdy     = rrdy_v[0];
  assign m2_rd_rrdy     = rrdy_v[1];
  assign m3_rd_rrdy     = rrdy_v[2];
  assign m4_rd_rrdy     = rrdy_v[3];
  assign m1_rd_rdata_en = en_v[0];
  assign m2_rd_rdata_en = en_v[1];
  assign m3_rd_rdata_en = en_v[2];
  assign m4_rd_rdata_en = en_v[3];
  assign m1_rd_data     = en_v[0] ? read_data : '0;
  assign m2_rd_data     = en_v[1] ? read_data : '0;
  assign m3_rd_data     = en_v[2] ? read_data : '0;
  assign m4_rd_data     = en_v[3] ? read_data : '0;
  assign m1_rd_rdone    = done_v[0];
  assign m2_rd_rdone    = done_v[1];
  assign m3_rd_rdone    = done_v[2];
  assign m4_rd_rdone    = done_v[3];

endmodule

// File: tb/tb_ddr_rd_arbit.sv
// Randomized and directed bench for ddr_rd_arbit against a transaction-level
// model of the arbitration and burst rules.
module tb_ddr_rd_arbit;

  localparam int AW  = 28;
  localparam int DQW = 32;
  localparam int LW  = 16;
  localparam int TMO = 16;
  localparam int DW  = 8*DQW;

  logic          ddr_clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req_d;
  logic [AW-1:0] addr_d [4];
  logic [LW-1:0] len_d [4];
  logic [3:0]    rrdy_o, en_o, rdone_o;
  logic [DW-1:0] data_o [4];
  logic          rd_cmd_en, rd_cmd_ready, read_data_valid, rd_cmd_done, rd_err;
  logic [AW-1:0] rd_cmd_addr;
  logic [31:0]   rd_cmd_len;
  logic [DW-1:0] read_data;

  always #5 ddr_clk = ~ddr_clk;

  ddr_rd_arbit #(.DDR_ADDR_WIDTH(AW), .DQ_WIDTH(DQW), .RD_LEN_WIDTH(LW), .TIMEOUT(TMO)) dut (
    .ddr_clk(ddr_clk), .rst(rst),
    .m1_rd_req(req_d[0]), .m1_rd_addr(addr_d[0]), .m1_rd_len(len_d[0]), .m1_rd_rrdy(rrdy_o[0]),
    .m1_rd_rdata_en(en_o[0]), .m1_rd_data(data_o[0]), .m1_rd_rdone(rdone_o[0]),
    .m2_rd_req(req_d[1]), .m2_rd_addr(addr_d[1]), .m2_rd_len(len_d[1]), .m2_rd_rrdy(rrdy_o[1]),
    .m2_rd_rdata_en(en_o[1]), .m2_rd_data(data_o[1]), .m2_rd_rdone(rdone_o[1]),
    .m3_rd_req(req_d[2]), .m3_rd_addr(addr_d[2]), .m3_rd_len(len_d[2]), .m3_rd_rrdy(rrdy_o[2]),
    .m3_rd_rdata_en(en_o[2]), .m3_rd_data(data_o[2]), .m3_rd_rdone(rdone_o[2]),
    .m4_rd_req(req_d[3]), .m4_rd_addr(addr_d[3]), .m4_rd_len(len_d[3]), .m4_rd_rrdy(rrdy_o[3]),
    .m4_rd_rdata_en(en_o[3]), .m4_rd_data(data_o[3]), .m4_rd_rdone(rdone_o[3]),
    .rd_cmd_en(rd_cmd_en), .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len),
    .rd_cmd_ready(rd_cmd_ready), .read_data(read_data), .read_data_valid(read_data_valid),
    .rd_cmd_done(rd_cmd_done), .rd_err(rd_err)
  );

  int checks = 0;
  int errors = 0;

  logic [3:0]    pend;
  logic [AW-1:0] m_addr [4];
  logic [LW-1:0] m_len [4];

  // Transaction model: 0 idle, 1 command, 2 data, 3 done.
  int            ph, cur, last, timer, beats, sent, stall_left, done_count;
  logic [AW-1:0] cur_addr;
  logic [LW-1:0] cur_len;
  bit            err_exp;

  bit rnd_mode, cfg_no_done, cfg_stray, cfg_hold_all;
  int cfg_stall, cfg_extra, cfg_short, req_pct, rst_hold;

  int cyc, en_cnt[4], cmd_en_cycles, rrdy_cnt, rrdy_cyc, rdone_cyc, done_cyc, first_cmd_cyc;
  int obs_log[$];

  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rrPick(input logic [3:0] r, input int lst);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (lst + k) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic applyStimulus();
    int target;
    rst = (rst_hold > 0);
    if (rst_hold > 0) rst_hold--;
    for (int i = 0; i < 4; i++) begin
      logic drop;
      if (cfg_hold_all && !pend[i]) begin
        pend[i] = 1'b1; m_addr[i] = AW'(32'h100 * (i + 1)); m_len[i] = LW'(2);
      end
      if (rnd_mode && !pend[i] && ($urandom_range(0, 99) < req_pct)) begin
        pend[i] = 1'b1; m_addr[i] = AW'($urandom); m_len[i] = LW'($urandom_range(0, 6));
      end
      drop = rnd_mode && (ph == 2) && (i == cur) && ($urandom_range(0, 3) == 0);
      req_d[i]  = pend[i] && !drop;
      addr_d[i] = pend[i] ? m_addr[i] : AW'($urandom);
      len_d[i]  = pend[i] ? m_len[i] : LW'($urandom);
    end
    valid_and_done_default();
    read_data    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    rd_cmd_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0;
    if (ph == 1) rd_cmd_ready = (stall_left == 0);
    if (ph == 2) begin
      target = (cfg_short >= 0) ? cfg_short : int'(cur_len) + cfg_extra;
      if (sent < target) read_data_valid = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!cfg_no_done) begin
        if (sent >= target) rd_cmd_done = 1'b1;
        else if (rnd_mode && read_data_valid && (sent + 1 == target) && ($urandom_range(0, 1) == 1))
          rd_cmd_done = 1'b1;
      end
    end
    if (cfg_stray && ph == 0) begin
      read_data_valid = 1'b1;
      cfg_stray = 1'b0;
    end
  endtask

  task automatic valid_and_done_default();
    read_data_valid = 1'b0;
    rd_cmd_done     = 1'b0;
  endtask

  task automatic checkCycle();
    logic [3:0] e_rrdy, e_en, e_done;
    logic       e_cmd, dlv;
    e_rrdy = '0; e_en = '0; e_done = '0; e_cmd = 1'b0; dlv = 1'b0;
    if (!rst) begin
      e_cmd = (ph == 1) && (cur_len != '0);
      if (ph == 1 && (cur_len == '0 || rd_cmd_ready)) e_rrdy[cur] = 1'b1;
      dlv = (ph == 2) && read_data_valid && (beats < int'(cur_len));
      if (dlv) e_en[cur] = 1'b1;
      if (ph == 3) e_done[cur] = 1'b1;
    end
    checkOutput("rd_cmd_en", DW'(rd_cmd_en), DW'(e_cmd));
    if (e_cmd) begin
      checkOutput("rd_cmd_addr", DW'(rd_cmd_addr), DW'(cur_addr));
      checkOutput("rd_cmd_len", DW'(rd_cmd_len), DW'(cur_len));
    end
    checkOutput("rrdy", DW'(rrdy_o), DW'(e_rrdy));
    checkOutput("rdata_en", DW'(en_o), DW'(e_en));
    checkOutput("rdone", DW'(rdone_o), DW'(e_done));
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("m%0d_rd_data", i + 1), data_o[i], e_en[i] ? read_data : '0);
    checkOutput("rd_err", DW'(rd_err), DW'(rst ? 1'b0 : err_exp));

    if (rst) begin
      ph = 0; last = 3; err_exp = 1'b0; timer = 0;
      return;
    end
    for (int i = 0; i < 4; i++) en_cnt[i] += int'(en_o[i]);
    if (rd_cmd_en) cmd_en_cycles++;
    if (rd_cmd_en && first_cmd_cyc < 0) first_cmd_cyc = cyc;
    if (|rrdy_o) begin rrdy_cnt++; rrdy_cyc = cyc; end
    if (|rdone_o) rdone_cyc = cyc;
    if (rd_cmd_done) done_cyc = cyc;
    for (int i = 0; i < 4; i++) if (rrdy_o[i]) obs_log.push_back(i);

    if (read_data_valid && ph != 2) err_exp = 1'b1;
    case (ph)
      0: begin
        int p;
        p = rrPick(req_d, last);
        if (p >= 0) begin
          cur = p; cur_addr = addr_d[p]; cur_len = len_d[p]; ph = 1;
          stall_left = rnd_mode ? $urandom_range(0, 2) : cfg_stall;
        end
      end
      1: begin
        if (cur_len == '0) ph = 3;
        else if (rd_cmd_ready) begin ph = 2; beats = 0; sent = 0; timer = 0; end
        else stall_left--;
      end
      2: begin
        if (read_data_valid) begin
          sent++;
          if (beats < int'(cur_len)) beats++;
          else err_exp = 1'b1;
        end
        if (rd_cmd_done) begin
          if (beats < int'(cur_len)) err_exp = 1'b1;
          ph = 3;
        end else if (timer == TMO - 1) begin
          err_exp = 1'b1; ph = 3;
        end else timer++;
      end
      default: begin
        last = cur; pend[cur] = 1'b0; ph = 0; done_count++;
      end
    endcase
  endtask

  task automatic stepCycle();
    @(posedge ddr_clk);
    #1;
    cyc++;
    applyStimulus();
    @(negedge ddr_clk);
    checkCycle();
  endtask

  task automatic doReset(input int n);
    pend = '0;
    rst_hold = n;
    repeat (n + 1) stepCycle();
  endtask

  task automatic clearStats();
    for (int i = 0; i < 4; i++) en_cnt[i] = 0;
    cmd_en_cycles = 0; rrdy_cnt = 0; rrdy_cyc = -1; rdone_cyc = -1; done_cyc = -1; first_cmd_cyc = -1;
    obs_log.delete();
  endtask

  task automatic runDones(input int n, input int maxc);
    int target, k;
    target = done_count + n;
    k = 0;
    while (done_count < target && k < maxc) begin stepCycle(); k++; end
    if (done_count < target) checkOutput("txn_budget", DW'(0), DW'(1));
  endtask

  task automatic drain(input int maxc);
    int k;
    k = 0;
    while ((ph != 0 || pend != '0) && k < maxc) begin stepCycle(); k++; end
    if (ph != 0 || pend != '0) checkOutput("drain_budget", DW'(0), DW'(1));
  endtask

  initial begin
    int raise_cyc;
    pend = '0; req_d = '0; rnd_mode = 0; cfg_no_done = 0; cfg_stray = 0; cfg_hold_all = 0;
    cfg_stall = 0; cfg_extra = 0; cfg_short = -1; req_pct = 20; rst_hold = 0;
    ph = 0; cur = 0; last = 3; err_exp = 0; done_count = 0; cyc = 0;
    cur_len = '0; cur_addr = '0; beats = 0; sent = 0; timer = 0; stall_left = 0;
    for (int i = 0; i < 4; i++) begin addr_d[i] = '0; len_d[i] = '0; m_addr[i] = '0; m_len[i] = '0; end
    rd_cmd_ready = 0; read_data_valid = 0; rd_cmd_done = 0; read_data = '0;
    clearStats();

    doReset(3);
    repeat (2) stepCycle();

    clearStats();
    pend[0] = 1'b1; m_addr[0] = 28'h0ABCDE0; m_len[0] = LW'(8);
    raise_cyc = cyc + 1;
    runDones(1, 100);
    checkOutput("m1_beats", DW'(en_cnt[0]), DW'(8));
    checkOutput("cmd_latency", DW'(first_cmd_cyc - raise_cyc), DW'(1));
    checkOutput("rdone_latency", DW'(rdone_cyc - done_cyc), DW'(1));

    clearStats();
    cfg_stall = 5;
    pend[1] = 1'b1; m_addr[1] = 28'h1234560; m_len[1] = LW'(3);
    runDones(1, 100);
    cfg_stall = 0;
    checkOutput("stall_cmd_cycles", DW'(cmd_en_cycles), DW'(6));
    checkOutput("stall_rrdy_pulses", DW'(rrdy_cnt), DW'(1));

    clearStats();
    pend[2] = 1'b1; m_addr[2] = 28'h0000040; m_len[2] = '0;
    runDones(1, 50);
    checkOutput("len0_cmd_cycles", DW'(cmd_en_cycles), DW'(0));
    checkOutput("len0_rrdy_pulses", DW'(rrdy_cnt), DW'(1));

    clearStats();
    cfg_extra = 2;
    pend[3] = 1'b1; m_addr[3] = 28'h0FFFFC0; m_len[3] = LW'(4);
    runDones(1, 100);
    cfg_extra = 0;
    checkOutput("overflow_beats", DW'(en_cnt[3]), DW'(4));
    stepCycle();
    checkOutput("overflow_err", DW'(rd_err), DW'(1));
    doReset(2);

    cfg_short = 2;
    pend[0] = 1'b1; m_addr[0] = 28'h0000100; m_len[0] = LW'(5);
    runDones(1, 100);
    cfg_short = -1;
    stepCycle();
    checkOutput("short_err", DW'(rd_err), DW'(1));
    doReset(2);

    clearStats();
    cfg_no_done = 1;
    pend[1] = 1'b1; m_addr[1] = 28'h0000200; m_len[1] = LW'(3);
    pend[2] = 1'b1; m_addr[2] = 28'h0000300; m_len[2] = LW'(2);
    runDones(1, 100);
    cfg_no_done = 0;
    checkOutput("timeout_span", DW'(rdone_cyc - rrdy_cyc), DW'(TMO + 1));
    runDones(1, 100);
    checkOutput("timeout_next_grant", DW'(obs_log[obs_log.size() - 1]), DW'(2));
    doReset(2);

    cfg_stray = 1;
    repeat (3) stepCycle();
    checkOutput("stray_err", DW'(rd_err), DW'(1));
    doReset(2);

    clearStats();
    cfg_hold_all = 1;
    runDones(8, 200);
    cfg_hold_all = 0;
    drain(200);
    for (int i = 0; i < 8; i++) begin
      if (i < obs_log.size()) checkOutput($sformatf("rr_order%0d", i), DW'(obs_log[i]), DW'(i % 4));
      else checkOutput($sformatf("rr_order%0d", i), DW'(0), DW'(1));
    end

    pend[2] = 1'b1; m_addr[2] = 28'h0000500; m_len[2] = LW'(6);
    begin
      int k;
      k = 0;
      while (!(ph == 2 && beats >= 2) && k < 50) begin stepCycle(); k++; end
      if (k >= 50) checkOutput("reach_data_budget", DW'(0), DW'(1));
    end
    doReset(1);
    clearStats();
    pend[1] = 1'b1; m_addr[1] = 28'h0000600; m_len[1] = LW'(1);
    pend[3] = 1'b1; m_addr[3] = 28'h0000700; m_len[3] = LW'(1);
    pend[0] = 1'b1; m_addr[0] = 28'h0000800; m_len[0] = LW'(1);
    runDones(1, 50);
    if (obs_log.size() > 0) checkOutput("post_reset_grant", DW'(obs_log[0]), DW'(0));
    else checkOutput("post_reset_grant", DW'(0), DW'(1));
    drain(200);

    doReset(2);
    rnd_mode = 1;
    repeat (3000) stepCycle();
    rnd_mode = 0;
    drain(500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
